// File: rtl/mem_bus_pkg.sv
// Shared memory-bus constants and the copy-engine state type.
package mem_bus_pkg;

  localparam int unsigned MEM_ADDR_W = 14;
  localparam int unsigned MEM_DATA_W = 16;
  localparam int unsigned MEM_WORDS  = 1 << MEM_ADDR_W;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } copy_state_e;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Memory-bus handshake between an initiator (master) and the arbiter/responders (slave).
interface mem_copy_engine_if
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) ();

  logic              busReq;
  logic              busGnt;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memDataOut;
  logic              memWrEn;
  logic [DATA_W-1:0] memDataIn;

  modport master (
    output busReq,
    output memAddr,
    output memDataOut,
    output memWrEn,
    input  busGnt,
    input  memDataIn
  );

  modport slave (
    input  busReq,
    input  memAddr,
    input  memDataOut,
    input  memWrEn,
    output busGnt,
    output memDataIn
  );

endinterface

// File: rtl/mem_copy_engine.sv
// Bus-initiator block copy: alternating read/write cycles while granted, strictly forward.
module mem_copy_engine
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned LEN_W  = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_srcAddr,
  input  logic [ADDR_W-1:0] i_dstAddr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  mem_copy_engine_if.master bus
);

  copy_state_e       state_q;
  logic [ADDR_W-1:0] src_ptr_q;
  logic [ADDR_W-1:0] dst_ptr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [DATA_W-1:0] data_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              req_q;

  logic [LEN_W:0]    src_end;
  logic [LEN_W:0]    dst_end;
  logic              range_bad;

  // Reject a start whose source or destination block would run past the top of memory.
  always_comb begin
    src_end   = (LEN_W+1)'(i_srcAddr) + (LEN_W+1)'(i_len);
    dst_end   = (LEN_W+1)'(i_dstAddr) + (LEN_W+1)'(i_len);
    range_bad = (src_end > (LEN_W+1)'(MEM_WORDS)) || (dst_end > (LEN_W+1)'(MEM_WORDS));
  end

  // Copy FSM with registered status and bus-request outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            if (i_len == '0) begin
              state_q <= StDone;
              busy_q  <= 1'b1;
              done_q  <= 1'b1;
            end else if (range_bad) begin
              err_q <= 1'b1;
            end else begin
              src_ptr_q   <= i_srcAddr;
              dst_ptr_q   <= i_dstAddr;
              remaining_q <= i_len;
              state_q     <= StRead;
              busy_q      <= 1'b1;
              req_q       <= 1'b1;
            end
          end
        end
        StRead: begin
          // The granted read completes even when abort is asserted in the same cycle.
          if (bus.busGnt) begin
            data_q    <= bus.memDataIn;
            src_ptr_q <= src_ptr_q + ADDR_W'(1);
          end
          if (i_abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
          end else if (bus.busGnt) begin
            state_q <= StWrite;
          end
        end
        StWrite: begin
          if (bus.busGnt) begin
            dst_ptr_q   <= dst_ptr_q + ADDR_W'(1);
            remaining_q <= remaining_q - LEN_W'(1);
          end
          if (i_abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
          end else if (bus.busGnt) begin
            if (remaining_q == LEN_W'(1)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              req_q   <= 1'b0;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Bus cycle is driven only while granted in READ or WRITE; otherwise the bus is quiet.
  always_comb begin
    bus.memAddr    = '0;
    bus.memDataOut = '0;
    bus.memWrEn    = 1'b0;
    if (bus.busGnt) begin
      if (state_q == StRead) begin
        bus.memAddr = src_ptr_q;
      end else if (state_q == StWrite) begin
        bus.memAddr    = dst_ptr_q;
        bus.memDataOut = data_q;
        bus.memWrEn    = 1'b1;
      end
    end
  end

  assign bus.busReq = req_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a bus-transaction reference model.
module tb_mem_copy_engine;
  import mem_bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic        abort;
  logic [13:0] src;
  logic [13:0] dst;
  logic [14:0] len;
  logic        busy;
  logic        done;
  logic        err;
  logic        gnt;

  mem_copy_engine_if bus ();

  mem_copy_engine dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_abort   (abort),
    .i_srcAddr (src),
    .i_dstAddr (dst),
    .i_len     (len),
    .o_busy    (busy),
    .o_done    (done),
    .o_err     (err),
    .bus       (bus)
  );

  // Bus responder memory, loaded through fill/poke requests and the engine's writes.
  logic [15:0] mem [0:16383];
  logic        fill_req;
  logic        poke_en;
  logic [13:0] poke_addr;
  logic [15:0] poke_data;

  assign bus.busGnt    = gnt;
  assign bus.memDataIn = mem[bus.memAddr];

  function automatic logic [15:0] pattern(input int a);
    return 16'(a) ^ 16'hC3A5;
  endfunction

  always @(posedge clk) begin
    if (fill_req) begin
      for (int a = 0; a < 16384; a++) mem[a] <= pattern(a);
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (bus.memWrEn) begin
      mem[bus.memAddr] <= bus.memDataOut;
    end
  end

  // Reference model: the ordered list of bus operations a copy must issue, plus a shadow memory.
  typedef struct packed {
    logic        wr;
    logic [13:0] addr;
  } op_t;

  op_t         ops_q[$];
  logic [15:0] shadow [0:16383];
  logic [15:0] rd_data;
  int          n_checks;
  int          n_fail;
  int          n_writes;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle bus check: the next pending operation happens in each granted cycle.
  task automatic bus_compare();
    op_t         op;
    logic [31:0] exp;
    logic [31:0] act;
    exp = {1'b0, 1'b0, 14'h0, 16'h0};
    if (ops_q.size() > 0) exp[31] = 1'b1;
    if (gnt && ops_q.size() > 0) begin
      op = ops_q.pop_front();
      if (op.wr) begin
        exp[30:0] = {1'b1, op.addr, rd_data};
        shadow[op.addr] = rd_data;
        n_writes++;
      end else begin
        exp[30:0] = {1'b0, op.addr, 16'h0};
        rd_data = shadow[op.addr];
      end
    end
    act = {bus.busReq, bus.memWrEn, bus.memAddr, bus.memDataOut};
    check("bus{req,we,addr,data}", act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    bus_compare();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [13:0] a, input logic [15:0] d);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    shadow[a] = d;
    step();
    poke_en = 1'b0;
  endtask

  // Pulses start for one cycle; on return we are just after the accepting edge T.
  task automatic start_copy(input logic [13:0] s, input logic [13:0] d, input logic [14:0] l);
    bit acc;
    src   = s;
    dst   = d;
    len   = l;
    start = 1'b1;
    step();
    start = 1'b0;
    acc = (l != 0) && (int'(s) + int'(l) <= MEM_WORDS) && (int'(d) + int'(l) <= MEM_WORDS);
    if (acc) begin
      for (int k = 0; k < int'(l); k++) begin
        ops_q.push_back('{wr: 1'b0, addr: 14'(int'(s) + k)});
        ops_q.push_back('{wr: 1'b1, addr: 14'(int'(d) + k)});
      end
    end
  endtask

  // Waits (bounded) for o_done; optionally drives the 1,0,0 grant pattern.
  task automatic finish_copy(input string name, input int exp_cyc, input bit toggle);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (toggle) gnt = (cyc % 3 == 0);
      step();
      cyc++;
    end
    gnt = 1'b1;
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({name, "_ops_left"}, 32'(ops_q.size()), 32'd0);
    step();
    check({name, "_done_drop"}, 32'(done), 32'd0);
    check({name, "_busy_drop"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int w0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; src = '0; dst = '0; len = '0; gnt = 1'b1;
    fill_req = 1'b0; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    n_checks = 0; n_fail = 0; n_writes = 0; rd_data = '0;
    @(posedge clk);
    #1;
    fill_req = 1'b1;
    for (int a = 0; a < 16384; a++) shadow[a] = pattern(a);
    step();
    fill_req = 1'b0;
    step();

    // Reset state with grant held high.
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_bus", {bus.busReq, bus.memWrEn, bus.memAddr, bus.memDataOut}, 32'd0);
    rst = 1'b0;
    step();

    // Continuous grant, len=4.
    poke(14'h0100, 16'h1234);
    poke(14'h0101, 16'h5678);
    poke(14'h0102, 16'h9ABC);
    poke(14'h0103, 16'hDEF0);
    start_copy(14'h0100, 14'h0200, 15'd4);
    check("t1_busy_T1", 32'(busy), 32'd1);
    check("t1_req_T1", 32'(bus.busReq), 32'd1);
    finish_copy("t1", 8, 1'b0);
    check("t1_mem200", 32'(mem[14'h0200]), 32'h1234);
    check("t1_mem201", 32'(mem[14'h0201]), 32'h5678);
    check("t1_mem202", 32'(mem[14'h0202]), 32'h9ABC);
    check("t1_mem203", 32'(mem[14'h0203]), 32'hDEF0);

    // Grant toggling 1,0,0 during a len=3 copy.
    poke(14'h0140, 16'h1111);
    poke(14'h0141, 16'h2222);
    poke(14'h0142, 16'h3333);
    w0 = n_writes;
    start_copy(14'h0140, 14'h0240, 15'd3);
    finish_copy("t2", 16, 1'b1);
    check("t2_writes", 32'(n_writes - w0), 32'd3);
    check("t2_mem242", 32'(mem[14'h0242]), 32'h3333);

    // len=0: done at T+1 with busy and no request.
    start_copy(14'h0000, 14'h0000, 15'd0);
    check("t3_len0_done", 32'(done), 32'd1);
    check("t3_len0_busy", 32'(busy), 32'd1);
    check("t3_len0_req", 32'(bus.busReq), 32'd0);
    step();
    check("t3_len0_done_drop", 32'(done), 32'd0);
    check("t3_len0_busy_drop", 32'(busy), 32'd0);

    // Source range overflow is rejected.
    start_copy(14'h3FFE, 14'h0000, 15'd3);
    check("t3_rej_err", 32'(err), 32'd1);
    check("t3_rej_busy", 32'(busy), 32'd0);
    check("t3_rej_req", 32'(bus.busReq), 32'd0);
    step();
    check("t3_rej_err_drop", 32'(err), 32'd0);

    // Destination ending exactly at the top of memory is accepted.
    poke(14'h0302, 16'hBEEF);
    start_copy(14'h0300, 14'h3FFD, 15'd3);
    check("t3_top_err", 32'(err), 32'd0);
    finish_copy("t3_top", 6, 1'b0);
    check("t3_top_mem3fff", 32'(mem[14'h3FFF]), 32'hBEEF);

    // Abort during the second WRITE of a len=8 copy.
    poke(14'h0400, 16'h4D4D);
    w0 = n_writes;
    start_copy(14'h0400, 14'h0500, 15'd8);
    step();
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    ops_q.delete();
    check("t4_writes", 32'(n_writes - w0), 32'd2);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_no_done", 32'(done), 32'd0);
    end
    start_copy(14'h0400, 14'h0600, 15'd1);
    finish_copy("t4_restart", 2, 1'b0);
    check("t4_mem600", 32'(mem[14'h0600]), 32'h4D4D);

    // Start pulsed mid-copy is ignored.
    start_copy(14'h0100, 14'h0700, 15'd4);
    step();
    src = 14'h3000; dst = 14'h3100; len = 15'd2; start = 1'b1;
    step();
    start = 1'b0;
    check("t5_no_err", 32'(err), 32'd0);
    finish_copy("t5", 6, 1'b0);
    check("t5_mem703", 32'(mem[14'h0703]), 32'hDEF0);

    // Reset asserted during a WRITE.
    w0 = n_writes;
    start_copy(14'h0100, 14'h0800, 15'd4);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ops_q.delete();
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_bus", {bus.busReq, bus.memWrEn, bus.memAddr, bus.memDataOut}, 32'd0);
    check("t5_rst_writes", 32'(n_writes - w0), 32'd1);
    step();
    check("t5_rst_mem800", 32'(mem[14'h0800]), 32'h1234);
    start_copy(14'h0101, 14'h0900, 15'd1);
    finish_copy("t5_after_rst", 2, 1'b0);
    check("t5_mem900", 32'(mem[14'h0900]), 32'h5678);

    // Overlapping forward copy replicates the first source word.
    poke(14'h0010, 16'h5A5A);
    start_copy(14'h0010, 14'h0011, 15'd3);
    finish_copy("t6", 6, 1'b0);
    check("t6_mem11", 32'(mem[14'h0011]), 32'h5A5A);
    check("t6_mem12", 32'(mem[14'h0012]), 32'h5A5A);
    check("t6_mem13", 32'(mem[14'h0013]), 32'h5A5A);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
